// File: rtl/ssp_tx_fifo.sv
// Transmit FIFO between the APB write side and the SSP serialiser.
// Offers one byte at a time on TxData/tx_ready and holds it stable for the whole frame.
module ssp_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             PCLK,
  input  logic             CLEAR_B,
  input  logic             PSEL,
  input  logic             PWRITE,
  input  logic [WIDTH-1:0] PWDATA,
  input  logic             transmit_complete,
  output logic [WIDTH-1:0] TxData,
  output logic             tx_ready,
  output logic             SSPTXINTR,
  output logic             tx_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             full_s;
  logic             empty_s;
  logic             wr_req_s;
  logic             wr_en_s;
  logic             pop_s;
  logic             drop_rdy_s;

  assign full_s    = (count_r == FULL_CNT);
  assign empty_s   = (count_r == (AW+1)'(0));
  assign wr_req_s  = PSEL && PWRITE;
  assign wr_en_s   = wr_req_s && !full_s;
  assign SSPTXINTR = full_s;

  // FSM state register
  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && transmit_complete) state_nxt_s = ST_OFFER;
        else                               state_nxt_s = ST_IDLE;
      end
      ST_OFFER: begin
        if (!transmit_complete) state_nxt_s = ST_BUSY;
        else                    state_nxt_s = ST_OFFER;
      end
      ST_BUSY: begin
        if (transmit_complete) state_nxt_s = ST_IDLE;
        else                   state_nxt_s = ST_BUSY;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: pop on IDLE->OFFER, withdraw the offer once the serialiser takes it
  always_comb begin
    pop_s      = 1'b0;
    drop_rdy_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && transmit_complete) pop_s = 1'b1;
        else                               pop_s = 1'b0;
      end
      ST_OFFER: begin
        if (!transmit_complete) drop_rdy_s = 1'b1;
        else                    drop_rdy_s = 1'b0;
      end
      default: begin
        pop_s      = 1'b0;
        drop_rdy_s = 1'b0;
      end
    endcase
  end

  // Storage array; contents need no reset
  always_ff @(posedge PCLK) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= PWDATA;
    end
  end

  // Pointers and occupancy; a write and a pop on the same edge leave count unchanged
  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered serialiser interface and sticky overflow flag
  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      TxData      <= {WIDTH{1'b0}};
      tx_ready    <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (pop_s) begin
        TxData   <= mem_r[rd_ptr_r];
        tx_ready <= 1'b1;
      end else if (drop_rdy_s) begin
        tx_ready <= 1'b0;
      end
      if (wr_req_s && full_s) tx_overflow <= 1'b1;
    end
  end

endmodule
